// File: rtl/serial_cmd_decoder_if.sv
// rtl/serial_cmd_decoder_if.sv - byte stream, register write and response signals of serial_cmd_decoder
interface serial_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_new_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic [7:0] tx_data;
  logic       tx_new_data;
  logic       tx_block;
  logic       busy;
  logic       err_csum;
  logic       err_timeout;

  modport master (
    input  rx_data, rx_new_data, tx_block,
    output wr_addr, wr_data, wr_en, tx_data, tx_new_data, busy, err_csum, err_timeout
  );

  modport slave (
    output rx_data, rx_new_data, tx_block,
    input  wr_addr, wr_data, wr_en, tx_data, tx_new_data, busy, err_csum, err_timeout
  );
endinterface

// File: rtl/serial_cmd_decoder.sv
// rtl/serial_cmd_decoder.sv - assembles sync/addr/data/csum frames into register writes
// and answers each complete frame with ACK or NAK; an inter-byte timeout drops truncated frames.
module serial_cmd_decoder #(
  parameter int unsigned TIMEOUT_CLK = 16300,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input logic                  clk,
  input logic                  rst,
  serial_cmd_decoder_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CLK) + 1;
  // Expiry is decided on the cycle whose increment would reach TIMEOUT_CLK-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLK - 2);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CSUM,
    SEND_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       addr_hold;
  logic [7:0]       data_hold;
  logic [7:0]       resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_hold       <= '0;
      data_hold       <= '0;
      resp            <= '0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.wr_en       <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_new_data <= 1'b0;
      bus.busy        <= 1'b0;
      bus.err_csum    <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.wr_en       <= 1'b0;
      bus.tx_new_data <= 1'b0;
      bus.err_csum    <= 1'b0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.rx_new_data && bus.rx_data == SYNC_BYTE) begin
            state    <= GET_ADDR;
            bus.busy <= 1'b1;
          end
        end
        GET_ADDR, GET_DATA, GET_CSUM: begin
          if (bus.rx_new_data) begin
            cnt <= '0;
            if (state == GET_ADDR) begin
              addr_hold <= bus.rx_data;
              state     <= GET_DATA;
            end else if (state == GET_DATA) begin
              data_hold <= bus.rx_data;
              state     <= GET_CSUM;
            end else begin
              if (bus.rx_data == (addr_hold ^ data_hold ^ SYNC_BYTE)) begin
                bus.wr_addr <= addr_hold;
                bus.wr_data <= data_hold;
                bus.wr_en   <= 1'b1;
                resp        <= ACK_BYTE;
              end else begin
                bus.err_csum <= 1'b1;
                resp         <= NAK_BYTE;
              end
              state <= SEND_RESP;
            end
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND_RESP: begin
          cnt <= '0;
          if (!bus.tx_block) begin
            bus.tx_data     <= resp;
            bus.tx_new_data <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cmd_decoder.sv
// tb/tb_serial_cmd_decoder.sv - scoreboard bench for serial_cmd_decoder
module tb_serial_cmd_decoder;
  localparam int         TMO  = 20;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum int {EV_WR, EV_CSUM, EV_TMO, EV_TX} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  ev_t        exp_q[$];
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;

  serial_cmd_decoder_if bus();

  serial_cmd_decoder #(
    .TIMEOUT_CLK(TMO),
    .SYNC_BYTE  (SYNC),
    .ACK_BYTE   (ACK),
    .NAK_BYTE   (NAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Strobe one byte; c is the cycle in which the decoder samples it.
  task automatic send_byte(input logic [7:0] b, output int c);
    bus.rx_data     = b;
    bus.rx_new_data = 1'b1;
    c               = cyc;
    tick();
    bus.rx_new_data = 1'b0;
  endtask

  // Frame-level reference: a frame is good iff csum == addr ^ data ^ sync.
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                              input int n, input int blk);
    if (c == (a ^ d ^ SYNC)) begin
      push(EV_WR, a, d, n + 1);
      last_wa = a;
      last_wd = d;
      push(EV_TX, ACK, 8'h00, n + 2 + blk);
    end else begin
      push(EV_CSUM, last_wa, last_wd, n + 1);
      push(EV_TX, NAK, 8'h00, n + 2 + blk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                          input int gap_max, input int blk, input bit inj, input logic [7:0] inj_b);
    int n;
    int inj_k;
    inj_k = (blk > 0) ? $urandom_range(0, blk - 1) : 0;
    send_byte(SYNC, n);
    idle($urandom_range(0, gap_max));
    send_byte(a, n);
    idle($urandom_range(0, gap_max));
    send_byte(d, n);
    idle($urandom_range(0, gap_max));
    if (blk > 0) bus.tx_block = 1'b1;
    send_byte(c, n);
    expect_frame(a, d, c, n, blk);
    for (int k = 0; k < blk; k++) begin
      if (inj && k == inj_k) begin
        bus.rx_data     = inj_b;
        bus.rx_new_data = 1'b1;
      end
      tick();
      bus.rx_new_data = 1'b0;
    end
    bus.tx_block = 1'b0;
    drain();
  endtask

  task automatic do_trunc(input int nb);
    int n;
    send_byte(SYNC, n);
    for (int i = 0; i < nb; i++) begin
      idle($urandom_range(0, 4));
      send_byte(8'($urandom), n);
    end
    push(EV_TMO, 8'h00, 8'h00, n + TMO);
    drain();
  endtask

  task automatic send_garbage(input logic [7:0] b);
    int n;
    send_byte(b, n);
    check("busy_idle_garbage", int'(bus.busy), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_tx_data"}, int'(bus.tx_data), 0);
    check({tag, "_tx_new_data"}, int'(bus.tx_new_data), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_err_csum"}, int'(bus.err_csum), 0);
    check({tag, "_err_timeout"}, int'(bus.err_timeout), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      int       nact;
      ev_t      e;
      ev_kind_t k;
      nact = int'(bus.wr_en) + int'(bus.err_csum) + int'(bus.err_timeout) + int'(bus.tx_new_data);
      if (nact > 1) begin
        check("events_per_cycle", nact, 1);
      end else if (nact == 1) begin
        k = bus.wr_en ? EV_WR : bus.err_csum ? EV_CSUM : bus.err_timeout ? EV_TMO : EV_TX;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", int'(k), int'(e.kind));
          check("event_cycle", cyc, e.cyc);
          case (e.kind)
            EV_WR, EV_CSUM: begin
              check("wr_addr", int'(bus.wr_addr), int'(e.a));
              check("wr_data", int'(bus.wr_data), int'(e.d));
              check("busy_in_frame", int'(bus.busy), 1);
            end
            EV_TMO: check("busy_after_timeout", int'(bus.busy), 0);
            default: begin
              check("tx_data", int'(bus.tx_data), int'(e.a));
              check("busy_at_tx", int'(bus.busy), 0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] c;
    int         blk;
    rst             = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_new_data = 1'b0;
    bus.tx_block    = 1'b0;
    idle(3);
    check_reset("por");
    rst = 1'b1;
    tick();

    do_frame(8'h10, 8'h3C, 8'h89, 0, 0, 1'b0, 8'h00);
    check("busy_after_good", int'(bus.busy), 0);
    do_frame(8'h10, 8'h3C, 8'h00, 0, 0, 1'b0, 8'h00);

    send_garbage(8'h00);
    send_garbage(8'hFF);
    do_frame(8'h01, 8'h02, 8'hA6, 0, 0, 1'b0, 8'h00);

    send_byte(SYNC, n);
    send_byte(8'h01, n);
    push(EV_TMO, 8'h00, 8'h00, n + TMO);
    drain();
    do_frame(8'h7E, 8'h81, 8'h7E ^ 8'h81 ^ SYNC, 2, 0, 1'b0, 8'h00);

    // A byte on the expiry cycle keeps the frame alive.
    send_byte(SYNC, n);
    send_byte(8'h22, n);
    idle(TMO - 2);
    send_byte(8'h33, n);
    send_byte(8'h22 ^ 8'h33 ^ SYNC, n);
    expect_frame(8'h22, 8'h33, 8'h22 ^ 8'h33 ^ SYNC, n, 0);
    drain();

    do_frame(8'h5A, 8'hC3, 8'h5A ^ 8'hC3 ^ SYNC, 2, 50, 1'b1, SYNC);

    send_byte(SYNC, n);
    send_byte(8'h10, n);
    #3 rst = 1'b0;
    #1 check_reset("rst_mid_frame");
    tick();
    rst     = 1'b1;
    last_wa = 8'h00;
    last_wd = 8'h00;
    send_byte(8'h3C, n);
    send_byte(8'h89, n);
    idle(5);
    check("busy_after_rst_frame", int'(bus.busy), 0);

    bus.tx_block = 1'b1;
    send_byte(SYNC, n);
    send_byte(8'h44, n);
    send_byte(8'h55, n);
    send_byte(8'h44 ^ 8'h55 ^ SYNC, n);
    push(EV_WR, 8'h44, 8'h55, n + 1);
    idle(4);
    #3 rst = 1'b0;
    #1 check_reset("rst_mid_resp");
    bus.tx_block = 1'b0;
    tick();
    rst     = 1'b1;
    last_wa = 8'h00;
    last_wd = 8'h00;
    idle(5);
    drain();

    repeat (60) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 8'($urandom);
          d = 8'($urandom);
          c = a ^ d ^ SYNC;
          if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
          blk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
          do_frame(a, d, c, 4, blk, ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom));
        end
        2: begin
          repeat ($urandom_range(1, 4)) begin
            a = 8'($urandom);
            if (a == SYNC) a = ~a;
            send_garbage(a);
          end
        end
        default: do_trunc($urandom_range(0, 2));
      endcase
      idle($urandom_range(0, 3));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
